// File: rtl/data_bus_bridge.sv
// Data-side memory stage: turns the core's single-cycle load/store into a
// req/ack bus transaction, stalling the core until completion, with timeout and sticky error capture.
module data_bus_bridge #(
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byte_enable,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        err_flag,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_flag_q, err_flag_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic valid_req;
  logic ack_hit;
  logic tmo_hit;
  logic err_evt;

  // A store wins when both strobes are high; empty byte mask is a no-op.
  assign valid_req = (MemWrite | MemRead) && (byte_enable != 4'b0000);
  assign ack_hit   = (state_q == BUSY) && bus_ack;
  // Timeout fires on the TIMEOUT-th BUSY cycle; a coincident ack takes priority.
  assign tmo_hit   = (state_q == BUSY) && !bus_ack &&
                     (({1'b0, cnt_q} + 9'd1) == {1'b0, TIMEOUT});
  assign err_evt   = (ack_hit && bus_err) || tmo_hit;

  // State register and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cnt_q      <= 8'd0;
      rdata_q    <= 32'd0;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_req) state_d = BUSY;
      BUSY:    if (ack_hit || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, cycle counter and returned data
  always_comb begin
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (valid_req) begin
          req_d.we    = MemWrite;
          req_d.addr  = ALUResult;
          req_d.wdata = WriteData;
          req_d.be    = byte_enable;
          cnt_d       = 8'd0;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (ack_hit) begin
          if (req_q.we)    rdata_d = 32'd0;
          else if (bus_err) rdata_d = ERR_DATA;
          else             rdata_d = bus_rdata;
        end else if (tmo_hit) begin
          rdata_d = req_q.we ? 32'd0 : ERR_DATA;
        end
      end
      default: ;
    endcase
  end

  // Sticky error capture: first address is kept unless cleared in the same cycle.
  always_comb begin
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    if (err_evt) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) err_addr_d = req_q.addr;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_addr_d = 32'd0;
    end
  end

  // Outputs; stall is gated by reset so the core sees reset values while held.
  always_comb begin
    stall    = 1'b0;
    bus_req  = 1'b0;
    ReadData = 32'd0;
    case (state_q)
      IDLE:    stall = n_rst && valid_req;
      BUSY: begin
        stall   = 1'b1;
        bus_req = 1'b1;
      end
      DONE:    ReadData = rdata_q;
      default: ;
    endcase
  end

  assign bus_we    = req_q.we;
  assign bus_addr  = {req_q.addr[31:2], 2'b00};
  assign bus_wdata = req_q.wdata;
  assign bus_be    = req_q.be;
  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed plus randomized checks of data_bus_bridge against a per-transaction
// outcome model (latency, returned data, sticky error state).
module tb_data_bus_bridge;

  localparam logic [7:0]  TMO  = 8'd4;
  localparam logic [31:0] EDAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        MemWrite, MemRead;
  logic [31:0] ALUResult, WriteData;
  logic [3:0]  byte_enable;
  logic [31:0] ReadData;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err, err_clr, err_flag;
  logic [31:0] bus_rdata, err_addr;

  int checks = 0;
  int failures = 0;

  // model of the sticky error state
  logic        m_flag;
  logic [31:0] m_addr;

  data_bus_bridge #(.TIMEOUT(TMO), .ERR_DATA(EDAT)) dut (
    .clk(clk), .n_rst(n_rst),
    .MemWrite(MemWrite), .MemRead(MemRead), .ALUResult(ALUResult),
    .WriteData(WriteData), .byte_enable(byte_enable),
    .ReadData(ReadData), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd"},    ReadData, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_req"},   {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"},    {31'd0, bus_we}, 32'd0);
    chk({tag, "_addr"},  bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_be"},    {28'd0, bus_be}, 32'd0);
    chk({tag, "_eflag"}, {31'd0, err_flag}, 32'd0);
    chk({tag, "_eaddr"}, err_addr, 32'd0);
  endtask

  // One core access. ack_dly = BUSY cycles before the ack cycle; >= TMO means no ack.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int ack_dly,
                        input logic err, input logic [31:0] rdata,
                        input logic clr_first, input logic clr_last);
    bit          done;
    bit          acked;
    bit          last;
    bit          evt;
    int          k;
    logic [31:0] exp_rd;
    @(negedge clk);
    MemWrite = wr; MemRead = rd; ALUResult = addr; WriteData = wdata;
    byte_enable = be; err_clr = clr_first;
    #1;
    if (clr_first) begin m_flag = 1'b0; m_addr = 32'd0; end
    if (!((wr | rd) && be != 4'b0000)) begin
      chk("noop_stall", {31'd0, stall}, 32'd0);
      @(negedge clk); err_clr = 1'b0; #1;
      chk("noop_req",    {31'd0, bus_req}, 32'd0);
      chk("noop_stall2", {31'd0, stall}, 32'd0);
      chk("noop_eflag",  {31'd0, err_flag}, {31'd0, m_flag});
      MemWrite = 1'b0; MemRead = 1'b0;
      return;
    end
    chk("idle_stall", {31'd0, stall}, 32'd1);
    chk("idle_req",   {31'd0, bus_req}, 32'd0);
    chk("idle_rd",    ReadData, 32'd0);
    k = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      last      = (k == ack_dly) || (k == int'(TMO) - 1);
      bus_ack   = (k == ack_dly);
      bus_err   = err;
      bus_rdata = rdata;
      err_clr   = clr_last && last;
      #1;
      chk("busy_req",   {31'd0, bus_req}, 32'd1);
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_rd",    ReadData, 32'd0);
      chk("busy_addr",  bus_addr, {addr[31:2], 2'b00});
      chk("busy_we",    {31'd0, bus_we}, {31'd0, wr});
      chk("busy_be",    {28'd0, bus_be}, {28'd0, be});
      if (wr) chk("busy_wdata", bus_wdata, wdata);
      if (last) done = 1;
      k++;
    end
    acked  = (ack_dly < int'(TMO));
    exp_rd = wr ? 32'd0 : ((acked && !err) ? rdata : EDAT);
    evt    = acked ? err : 1'b1;
    if (evt) begin
      if (!m_flag || clr_last) m_addr = addr;
      m_flag = 1'b1;
    end else if (clr_last) begin
      m_flag = 1'b0; m_addr = 32'd0;
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0; err_clr = 1'b0;
    #1;
    chk("done_req",   {31'd0, bus_req}, 32'd0);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_rd",    ReadData, exp_rd);
    chk("done_eflag", {31'd0, err_flag}, {31'd0, m_flag});
    chk("done_eaddr", err_addr, m_addr);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    #1;
    chk("post_rd",    ReadData, 32'd0);
    chk("post_req",   {31'd0, bus_req}, 32'd0);
    chk("post_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_flag = 1'b0; m_addr = 32'd0;
    #1;
    chk("clr_eflag", {31'd0, err_flag}, 32'd0);
    chk("clr_eaddr", err_addr, 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    MemWrite = 1'b0; MemRead = 1'b0; ALUResult = 32'd0; WriteData = 32'd0;
    byte_enable = 4'b0; bus_ack = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0; err_clr = 1'b0;
    m_flag = 1'b0; m_addr = 32'd0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;

    // read, ack on second BUSY cycle
    access(1'b0, 1'b1, 32'h2000_0006, 32'h0, 4'b0100, 1, 1'b0, 32'h1122_3344, 1'b0, 1'b0);
    // write, immediate ack
    access(1'b1, 1'b0, 32'h2000_0010, 32'hA5A5_0000, 4'b1100, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // two timeouts: first address kept
    access(1'b0, 1'b1, 32'h3000_0008, 32'h0, 4'b1111, int'(TMO), 1'b0, 32'h0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'h3000_0100, 32'h0, 4'b0011, int'(TMO), 1'b0, 32'h0, 1'b0, 1'b0);
    clear_err();
    // ack in the same cycle as timeout: no error
    access(1'b0, 1'b1, 32'h3000_0200, 32'h0, 4'b0001, int'(TMO) - 1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
    // bus_err on write, then clear
    access(1'b1, 1'b0, 32'h4000_0000, 32'h1234_5678, 4'b1111, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    clear_err();
    // error with flag already set, coincident clear: new address wins
    access(1'b1, 1'b0, 32'h4000_0040, 32'h1, 4'b0001, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 32'h4000_0080, 32'h0, 4'b1000, 2, 1'b1, 32'h5555_5555, 1'b0, 1'b1);
    // no-op and write/read conflict
    access(1'b0, 1'b1, 32'h5000_0000, 32'h0, 4'b0000, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    access(1'b1, 1'b1, 32'h5000_0004, 32'hCAFE_0001, 4'b0110, 1, 1'b0, 32'h7777_7777, 1'b0, 1'b0);

    // reset mid-BUSY, then a late ack must be ignored
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h6000_0000; byte_enable = 4'hF;
    @(negedge clk); #1;
    chk("rst_busy_req", {31'd0, bus_req}, 32'd1);
    n_rst = 1'b0;
    #1;
    m_flag = 1'b0; m_addr = 32'd0;
    chk_reset_outputs("midrst");
    @(negedge clk); MemRead = 1'b0; byte_enable = 4'h0;
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h9999_9999; #1;
    chk("late_ack_req",   {31'd0, bus_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("late_ack_req2", {31'd0, bus_req}, 32'd0);
    chk("late_ack_rd",   ReadData, 32'd0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
             4'($urandom_range(0, 15)), int'($urandom_range(0, int'(TMO))),
             ($urandom_range(0, 3) == 0), $urandom(),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
